// File: rtl/mig_pkg.sv
// Shared types and width helpers for the sequential majority-inverter-graph evaluator.
package mig_pkg;

    // Fanin index storage width; covers up to 256 signals (constant + PIs + nodes).
    localparam int unsigned IDX_MAX_W = 8;

    typedef enum logic [1:0] {
        StIdle,
        StEval,
        StDone
    } state_t;

    typedef struct packed {
        logic                 inv;
        logic [IDX_MAX_W-1:0] idx;
    } fanin_t;

    typedef struct packed {
        fanin_t f2;
        fanin_t f1;
        fanin_t f0;
    } node_t;

    function automatic int unsigned idx_w(input int unsigned num_pi,
                                          input int unsigned num_nodes);
        return $clog2(1 + num_pi + num_nodes);
    endfunction

    function automatic int unsigned node_w(input int unsigned num_pi,
                                           input int unsigned num_nodes);
        return 3 * (idx_w(num_pi, num_nodes) + 1);
    endfunction

    function automatic int unsigned addr_w(input int unsigned num_nodes);
        return (num_nodes > 1) ? $clog2(num_nodes) : 1;
    endfunction

endpackage

// File: rtl/mig_seq_eval_if.sv
// Config, input-vector and result handshake bundle for mig_seq_eval.
interface mig_seq_eval_if
    import mig_pkg::*;
#(
    parameter int unsigned NUM_PI    = 5,
    parameter int unsigned NUM_NODES = 16
);
    localparam int unsigned IDX_W  = idx_w(NUM_PI, NUM_NODES);
    localparam int unsigned NODE_W = node_w(NUM_PI, NUM_NODES);
    localparam int unsigned ADDR_W = addr_w(NUM_NODES);

    logic              cfg_we;
    logic [ADDR_W-1:0] cfg_addr;
    logic [NODE_W-1:0] cfg_data;
    logic [IDX_W-1:0]  po_sel;
    logic              po_inv;
    logic              in_valid;
    logic              in_ready;
    logic [NUM_PI-1:0] in_pi;
    logic              out_valid;
    logic              out_ready;
    logic              out_po;
    logic              busy;

    modport master (
        output cfg_we, cfg_addr, cfg_data, po_sel, po_inv, in_valid, in_pi, out_ready,
        input  in_ready, out_valid, out_po, busy
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, po_sel, po_inv, in_valid, in_pi, out_ready,
        output in_ready, out_valid, out_po, busy
    );

endinterface

// File: rtl/mig_node_eval.sv
// Combinational evaluation of one majority node: three index muxes over
// {constant 0, PIs, node values}, per-fanin complement, 3-input majority.
module mig_node_eval
    import mig_pkg::*;
#(
    parameter int unsigned NUM_PI    = 5,
    parameter int unsigned NUM_NODES = 16
) (
    input  node_t                node,
    input  logic [NUM_PI-1:0]    pi,
    input  logic [NUM_NODES-1:0] vals,
    output logic                 v
);
    localparam int unsigned NUM_SIG = 1 + NUM_PI + NUM_NODES;

    logic [NUM_SIG-1:0] sig;
    logic               s0, s1, s2;

    assign sig = {vals, pi, 1'b0};

    // Indices past the last node fall through to 0.
    function automatic logic pick(input fanin_t f, input logic [NUM_SIG-1:0] s);
        logic b;
        b = 1'b0;
        for (int i = 0; i < int'(NUM_SIG); i++) begin
            if (f.idx == IDX_MAX_W'(i)) b = s[i];
        end
        return b ^ f.inv;
    endfunction

    always_comb begin
        s0 = pick(node.f0, sig);
        s1 = pick(node.f1, sig);
        s2 = pick(node.f2, sig);
        v  = (s0 & s1) | (s0 & s2) | (s1 & s2);
    end

endmodule

// File: rtl/mig_seq_eval.sv
// Sequential MIG evaluator: programmable node store, one node evaluated per
// clock, selected (optionally inverted) signal returned over valid/ready.
module mig_seq_eval
    import mig_pkg::*;
#(
    parameter int unsigned NUM_PI    = 5,
    parameter int unsigned NUM_NODES = 16
) (
    input logic            clk,
    input logic            rst_n,
    mig_seq_eval_if.slave  bus
);
    localparam int unsigned IDX_W  = idx_w(NUM_PI, NUM_NODES);
    localparam int unsigned NODE_W = node_w(NUM_PI, NUM_NODES);
    localparam int unsigned ADDR_W = addr_w(NUM_NODES);

    state_t               state_q, state_d;
    logic [NODE_W-1:0]    cfg_q [NUM_NODES];
    logic [NUM_NODES-1:0] vals_q;
    logic [NUM_PI-1:0]    pi_q;
    logic [IDX_W-1:0]     sel_q;
    logic                 inv_q;
    logic [ADDR_W-1:0]    cnt_q;

    logic  accept, cfg_wr, last;
    logic  in_ready, out_valid, busy;
    logic  node_v, sel_v;
    node_t cur_node, out_node;

    function automatic fanin_t dec(input logic [IDX_W:0] raw);
        fanin_t f;
        f.inv = raw[IDX_W];
        f.idx = IDX_MAX_W'(raw[IDX_W-1:0]);
        return f;
    endfunction

    assign accept = (state_q == StIdle) && bus.in_valid;
    assign cfg_wr = (state_q == StIdle) && bus.cfg_we && (32'(bus.cfg_addr) < NUM_NODES);
    assign last   = (cnt_q == ADDR_W'(NUM_NODES - 1));

    always_comb begin
        cur_node.f0 = dec(cfg_q[cnt_q][IDX_W:0]);
        cur_node.f1 = dec(cfg_q[cnt_q][2*IDX_W+1 -: IDX_W+1]);
        cur_node.f2 = dec(cfg_q[cnt_q][NODE_W-1 -: IDX_W+1]);
    end

    // Output select reuses the node mux: MAJ(x, x, x) == x.
    always_comb begin
        out_node.f0 = '{inv: inv_q, idx: IDX_MAX_W'(sel_q)};
        out_node.f1 = out_node.f0;
        out_node.f2 = out_node.f0;
    end

    mig_node_eval #(
        .NUM_PI    (NUM_PI),
        .NUM_NODES (NUM_NODES)
    ) u_node_eval (
        .node (cur_node),
        .pi   (pi_q),
        .vals (vals_q),
        .v    (node_v)
    );

    mig_node_eval #(
        .NUM_PI    (NUM_PI),
        .NUM_NODES (NUM_NODES)
    ) u_out_eval (
        .node (out_node),
        .pi   (pi_q),
        .vals (vals_q),
        .v    (sel_v)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_NODES); i++) cfg_q[i] <= '0;
        end else if (cfg_wr) begin
            cfg_q[bus.cfg_addr] <= bus.cfg_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            vals_q  <= '0;
            pi_q    <= '0;
            sel_q   <= '0;
            inv_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                // Clearing values makes forward/self references read 0 for this run.
                vals_q <= '0;
                pi_q   <= bus.in_pi;
                sel_q  <= bus.po_sel;
                inv_q  <= bus.po_inv;
                cnt_q  <= '0;
            end else if (state_q == StEval) begin
                vals_q[cnt_q] <= node_v;
                cnt_q         <= cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (bus.in_valid) state_d = StEval;
            end
            StEval: begin
                busy = 1'b1;
                if (last) state_d = StDone;
            end
            StDone: begin
                out_valid = 1'b1;
                if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.busy      = busy;
    assign bus.out_po    = out_valid & sel_v;

endmodule
